// File: rtl/button_event_detector.sv
// Turns the debounced button level into one-cycle press/release/short/long strobes.
// Define BTN_AUTOREPEAT_EN to add periodic repeat_pulse strobes while a long press is held.
module button_event_detector #(
  parameter int LONG_CNT   = 50000000,
  parameter int REPEAT_CNT = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAX_CNT = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  typedef enum logic [1:0] {
    WAIT_REL  = 2'd0,
    IDLE      = 2'd1,
    PRESSED   = 2'd2,
    LONG_HELD = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n, release_n, short_n, long_n, held_n, repeat_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_REL;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      short_pulse   <= short_n;
      long_pulse    <= long_n;
      held          <= held_n;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  always_ff @(posedge clk) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= repeat_n;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      // A level already high here is never treated as a press.
      WAIT_REL: begin
        if (!btn_level) state_n = IDLE;
      end
      IDLE: begin
        if (btn_level) begin
          state_n = PRESSED;
          cnt_n   = '0;
          press_n = 1'b1;
        end
      end
      // Release is checked first so it wins over reaching the long threshold.
      PRESSED: begin
        if (!btn_level) begin
          state_n   = IDLE;
          cnt_n     = '0;
          release_n = 1'b1;
          short_n   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = LONG_HELD;
          cnt_n   = '0;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_n   = IDLE;
          cnt_n     = '0;
          release_n = 1'b1;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == REPEAT_LAST) begin
            cnt_n    = '0;
            repeat_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
`else
          cnt_n = '0;
`endif
        end
      end
      default: begin
        state_n = WAIT_REL;
        cnt_n   = '0;
      end
    endcase
    held_n = (state_n == PRESSED) || (state_n == LONG_HELD);
  end

endmodule

// File: doc/button_event_detector.md
Name: button_event_detector

Overview:
- Sits directly downstream of the button debouncer in the FPGA controller.
- Consumes the filtered, synchronized button level and converts it into single-cycle event strobes: press, release, short-press, long-press and, optionally, auto-repeat.
- Strobes feed the controller's command/menu logic, so each physical action yields exactly one strobe per event type.

Parameters:
- LONG_CNT, 50000000, hold duration in clk cycles (counted from the press edge) that qualifies a long press; must be >= 2.
- REPEAT_CNT, 10000000, auto-repeat period in clk cycles once in long-hold; must be >= 2; used only with BTN_AUTOREPEAT_EN.
- CNT_W, derived as $clog2(max(LONG_CNT, REPEAT_CNT)), width of the single shared hold counter; localparam, not overridable.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active high.
- btn_level  input  1  debounced, already-synchronized button level; 1 = pressed. No internal synchronizer.
- press_pulse  output  1  one-cycle strobe on press.
- release_pulse  output  1  one-cycle strobe on every release.
- short_pulse  output  1  one-cycle strobe on release before the long threshold.
- long_pulse  output  1  one-cycle strobe when the hold reaches LONG_CNT.
- repeat_pulse  output  1  one-cycle auto-repeat strobe during long-hold; constant 0 without the macro.
- held  output  1  registered: 1 while state is PRESSED or LONG_HELD.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all outputs = 0, hold counter = 0, state = WAIT_REL.
- All outputs are registered. Each strobe is high for exactly the one cycle following the clk edge that decides it.
- States:
  - WAIT_REL: a button held at reset, or stuck high, never produces a press. Go to IDLE at the first edge sampling btn_level = 0. No strobes.
  - IDLE: on an edge with btn_level = 1, go to PRESSED, clear counter to 0, set press_pulse.
  - PRESSED:
    - btn_level = 0: go to IDLE, set release_pulse and short_pulse.
    - else if counter == LONG_CNT-1: go to LONG_HELD, set long_pulse, clear counter.
    - else: increment counter.
  - LONG_HELD:
    - btn_level = 0: go to IDLE, set release_pulse only.
    - else: counter runs per BTN_AUTOREPEAT_EN.
- Timing: long_pulse occurs LONG_CNT edges after the press edge. A release sampled at that same edge wins: short_pulse, no long_pulse.
- At most one of press, long and repeat strobes in any cycle. release_pulse coincides only with short_pulse.
- Counter saturation: without auto-repeat, the counter holds at 0 in LONG_HELD. It never wraps into a spurious event.
- A one-cycle btn_level high (IDLE → PRESSED → IDLE) yields press_pulse, then release_pulse + short_pulse on the next cycle.
- Reset asserted mid-press: next cycle all strobes = 0, held = 0, state = WAIT_REL. No release strobe is emitted for the aborted press.
- Illegal or unused state encodings recover to WAIT_REL.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: in LONG_HELD with btn_level = 1, counter increments. At counter == REPEAT_CNT-1, set repeat_pulse and clear the counter. First repeat comes REPEAT_CNT edges after long_pulse, then every REPEAT_CNT edges until release.
- Undefined: repeat_pulse is tied to 0, REPEAT_CNT is ignored, and the counter holds at 0 in LONG_HELD.

Test Plan (LONG_CNT=8, REPEAT_CNT=4 overrides):
- Reset with btn_level=1 held 20 cycles, then 0 for 2, then 1 → no strobes during the held period; press_pulse exactly once, one cycle after the 1 is sampled.
- Press held 5 cycles, then release → press_pulse once; release_pulse and short_pulse together one cycle after the release edge; long_pulse never.
- Press held 20 cycles → long_pulse exactly at edge 8 after the press edge, held=1 throughout; on release, release_pulse only, no short_pulse.
- Release sampled at exactly the 8th edge → short_pulse + release_pulse, no long_pulse.
- BTN_AUTOREPEAT_EN, press held 30 cycles → long_pulse at +8, repeat_pulse at +12, +16, +20, +24, +28; none after release. Without the macro, repeat_pulse stays 0.
- rst asserted 3 cycles into a press → all outputs 0 the next cycle; after rst drops with btn_level still 1, no strobes until btn_level goes 0 then 1.
